hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and next-PC sequencing controller for the 5-stage MIPS pipeline.
- Decides each cycle whether the next-PC unit may advance, must hold (its two stall inputs), or must flush IF/ID after a redirect.
- Detects load-use and branch-operand hazards.
- Owns the multiply/divide busy window through a latency counter FSM.
- Sits beside the ID stage and drives the npc stall inputs, the IF/ID write enable/flush and the ID/EX bubble.

Parameters:
- REG_W, 5, register-address width.
- MD_CYCLES, 8, cycles a mult/div occupies HI/LO after entering EX (legal range 2..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_pc_sel  in  2  ID PC select: 00 seq, 01 beq, 10 j/jal, 11 jr.
- id_md_op  in  1  ID instruction is mult/div/mthi/mtlo.
- id_md_read  in  1  ID instruction is mfhi/mflo.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_wa  in  REG_W  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_md_op  in  1  mult/div is in EX this cycle.
- mem_wreg  in  1  MEM instruction writes the register file.
- mem_wa  in  REG_W  MEM destination register.
- mem_mem_read  in  1  MEM instruction is a load.
- redirect  in  1  Flush output of npc.
- stall1  out  1  data-hazard stall, to npc Stall1.
- stall2  out  1  MDU stall, to npc Stall2.
- ifid_we  out  1  IF/ID register write enable.
- flush_ifid  out  1  clear IF/ID to NOP.
- bubble_idex  out  1  load NOP into ID/EX.
- md_busy  out  1  HI/LO result pending.
- md_done  out  1  one-cycle pulse when the MDU window closes.
- perf_stall  out  32  stall-cycle counter.
- perf_flush  out  32  flush counter.

Behaviour:
- Match definitions:
  - rs_ex = id_use_rs & ex_wreg & (ex_wa!=0) & (ex_wa==id_rs); rt_ex is the same with rt.
  - rs_mem and rt_mem are the same using mem_wreg and mem_wa. Register 0 never matches.
- stall1 (combinational from inputs):
  - ex_mem_read & (rs_ex | rt_ex), the load-use hazard.
  - OR (id_pc_sel==01 | id_pc_sel==11) & (rs_ex | rt_ex): branch/jr compare in ID needs an EX result.
  - OR (id_pc_sel==01 | id_pc_sel==11) & mem_mem_read & (rs_mem | rt_mem).
  - j/jal (10) never causes stall1.
- stall2 = md_busy & (id_md_op | id_md_read).
- ifid_we = ~(stall1 | stall2).
- bubble_idex = stall1 | stall2.
- flush_ifid = redirect & ~stall1 & ~stall2. A stall always overrides a redirect, consistent with npc holding the PC.
- MDU FSM, states RUN and BUSY, 8-bit counter cnt:
  - RUN: when ex_md_op=1, go to BUSY next edge with cnt=MD_CYCLES-1. md_busy=0 in RUN.
  - BUSY: md_busy=1; cnt decrements each cycle.
  - BUSY with cnt==0: go to RUN next edge; md_done=1 during that final BUSY cycle.
  - ex_md_op while in BUSY is ignored; it cannot occur because stall2 blocks it in ID.
  - Resulting window: ex_md_op at edge N gives md_busy high for exactly MD_CYCLES cycles starting at cycle N+1.
- Reset:
  - rst=1 at an edge forces RUN, cnt=0, md_busy=0, md_done=0, perf counters=0.
  - Combinational outputs follow their inputs; with all inputs 0, stall1=0, stall2=0, ifid_we=1, flush_ifid=0, bubble_idex=0.
  - Reset mid-BUSY aborts the window with no md_done pulse.
- Simultaneous events: a load-use hazard and an MDU stall in the same cycle give stall1=1 and stall2=1, and count as one perf_stall cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall increments every cycle (stall1|stall2) is 1.
  - perf_flush increments every cycle flush_ifid is 1.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: ex_mem_read=1, ex_wreg=1, ex_wa=8, id_rs=8, id_use_rs=1 -> stall1=1, ifid_we=0, bubble_idex=1; with ex_wa=0 -> stall1=0.
- Branch dependency: id_pc_sel=01, ex_wreg=1, ex_wa=5, id_rt=5, id_use_rt=1 -> stall1=1; id_pc_sel=10 with the same operands -> stall1=0.
- MDU window, MD_CYCLES=8: pulse ex_md_op at edge 0 -> md_busy=1 for cycles 1..8, md_done=1 only in cycle 8; id_md_read=1 in cycle 4 -> stall2=1; cycle 9 -> stall2=0.
- Redirect vs stall: redirect=1 with stall1=1 -> flush_ifid=0; next cycle with the hazard cleared -> flush_ifid=1.
- Reset mid-BUSY: rst at cycle 3 of the window -> md_busy=0 next cycle, no md_done; a new ex_md_op restarts the full 8-cycle window.
- HAZARD_PERF_EN: 3 stall cycles + 2 flushes -> perf_stall=3, perf_flush=2; rst -> both 0; macro undefined -> both read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: ID/EX/MEM pipeline fields in, stall/flush/MDU status out.
// master = pipeline side driving the fields, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [1:0]       id_pc_sel;
  logic             id_md_op;
  logic             id_md_read;
  logic             ex_wreg;
  logic [REG_W-1:0] ex_wa;
  logic             ex_mem_read;
  logic             ex_md_op;
  logic             mem_wreg;
  logic [REG_W-1:0] mem_wa;
  logic             mem_mem_read;
  logic             redirect;

  logic             stall1;
  logic             stall2;
  logic             ifid_we;
  logic             flush_ifid;
  logic             bubble_idex;
  logic             md_busy;
  logic             md_done;
  logic [31:0]      perf_stall;
  logic [31:0]      perf_flush;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_pc_sel, id_md_op, id_md_read,
           ex_wreg, ex_wa, ex_mem_read, ex_md_op, mem_wreg, mem_wa, mem_mem_read,
           redirect,
    input  stall1, stall2, ifid_we, flush_ifid, bubble_idex, md_busy, md_done,
           perf_stall, perf_flush
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_pc_sel, id_md_op, id_md_read,
           ex_wreg, ex_wa, ex_mem_read, ex_md_op, mem_wreg, mem_wa, mem_mem_read,
           redirect,
    output stall1, stall2, ifid_we, flush_ifid, bubble_idex, md_busy, md_done,
           perf_stall, perf_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and next-PC sequencing controller for the 5-stage MIPS pipeline (load-use, branch operands, MDU window).
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int MD_CYCLES = 8   // legal range 2..255
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam logic [7:0] CNT_LOAD = 8'(MD_CYCLES - 1);

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic dep(input logic             use_r,
                               input logic [REG_W-1:0] r,
                               input logic             wreg,
                               input logic [REG_W-1:0] wa);
    return use_r & wreg & (wa != '0) & (wa == r);
  endfunction

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic ex_dep, mem_dep, cmp_in_id;
  logic stall1, stall2, stall_any;
  logic md_busy, md_done;

  assign rs_ex  = dep(hz.id_use_rs, hz.id_rs, hz.ex_wreg,  hz.ex_wa);
  assign rt_ex  = dep(hz.id_use_rt, hz.id_rt, hz.ex_wreg,  hz.ex_wa);
  assign rs_mem = dep(hz.id_use_rs, hz.id_rs, hz.mem_wreg, hz.mem_wa);
  assign rt_mem = dep(hz.id_use_rt, hz.id_rt, hz.mem_wreg, hz.mem_wa);

  assign ex_dep    = rs_ex | rt_ex;
  assign mem_dep   = rs_mem | rt_mem;
  // beq and jr compare their operands in ID; j/jal need no register.
  assign cmp_in_id = (hz.id_pc_sel == 2'b01) | (hz.id_pc_sel == 2'b11);

  assign stall1    = (hz.ex_mem_read & ex_dep)
                   | (cmp_in_id & ex_dep)
                   | (cmp_in_id & hz.mem_mem_read & mem_dep);
  assign stall2    = md_busy & (hz.id_md_op | hz.id_md_read);
  assign stall_any = stall1 | stall2;

  assign hz.stall1      = stall1;
  assign hz.stall2      = stall2;
  assign hz.ifid_we     = ~stall_any;
  assign hz.bubble_idex = stall_any;
  // A stall holds the PC, so a redirect must wait until the stall clears.
  assign hz.flush_ifid  = hz.redirect & ~stall_any;

  md_state_e  state, state_nx;
  logic [7:0] cnt, cnt_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_md_op) begin
          state_nx = BUSY;
          cnt_nx   = CNT_LOAD;
        end
      end
      BUSY: begin
        // ex_md_op cannot arrive here: stall2 keeps any MDU op parked in ID.
        md_busy = 1'b1;
        if (cnt == 8'd0) begin
          md_done  = 1'b1;
          state_nx = RUN;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign hz.md_busy = md_busy;
  assign hz.md_done = md_done;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // A cycle with both stall sources counts once; both counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_any)     perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.flush_ifid) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall = perf_stall_q;
  assign hz.perf_flush = perf_flush_q;
`else
  assign hz.perf_stall = '0;
  assign hz.perf_flush = '0;
`endif

endmodule
